// File: rtl/integrate_dump_if.sv
// Sample stream into the integrate-and-dump decimator and block-sum stream out of it.
// master = upstream/driver side, slave = the decimator itself.
interface integrate_dump_if #(
    parameter int WDTH      = 32,
    parameter int LOG_DECIM = 3,
    parameter int MWDTH     = 1
);
    logic signed [WDTH-1:0]           in_data;
    logic                             in_nd;
    logic        [MWDTH-1:0]          in_m;
    logic                             in_start;
    logic signed [WDTH+LOG_DECIM-1:0] out_data;
    logic                             out_nd;
    logic        [MWDTH-1:0]          out_m;
    logic                             error;

    modport master (
        output in_data,
        output in_nd,
        output in_m,
        output in_start,
        input  out_data,
        input  out_nd,
        input  out_m,
        input  error
    );

    modport slave (
        input  in_data,
        input  in_nd,
        input  in_m,
        input  in_start,
        output out_data,
        output out_nd,
        output out_m,
        output error
    );
endinterface

// File: rtl/integrate_dump.sv
// Integrate-and-dump decimator: sums each block of DECIM valid samples into one widened sum,
// tagged with the block's first metadata; a mid-block start marker restarts the block and sets a sticky error.
module integrate_dump #(
    parameter int WDTH      = 32,
    parameter int DECIM     = 8,
    parameter int LOG_DECIM = 3,
    parameter int MWDTH     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    integrate_dump_if.slave   io_stream
);
    localparam int OW = WDTH + LOG_DECIM;
    localparam int CW = LOG_DECIM;

    logic        [CW-1:0]    r_cnt;
    logic signed [OW-1:0]    r_acc;
    logic        [MWDTH-1:0] r_m;
    logic signed [OW-1:0]    r_outData;
    logic                    r_outNd;
    logic        [MWDTH-1:0] r_outM;
    logic                    r_error;

    logic        [CW-1:0]    w_cntNext;
    logic signed [OW-1:0]    w_accNext;
    logic        [MWDTH-1:0] w_mNext;
    logic signed [OW-1:0]    w_outDataNext;
    logic                    w_outNdNext;
    logic        [MWDTH-1:0] w_outMNext;
    logic                    w_errorNext;
    logic signed [OW-1:0]    w_ext;
    logic                    w_blockEmpty;
    logic                    w_lastSample;

    assign w_ext        = {{LOG_DECIM{io_stream.in_data[WDTH-1]}}, io_stream.in_data};
    assign w_blockEmpty = (r_cnt == '0);
    assign w_lastSample = (r_cnt == CW'(DECIM - 1));

    // A start marker always opens a fresh block; it is only an error when a block was already open,
    // and that check wins over a dump on the final sample.
    always_comb begin
        w_cntNext     = r_cnt;
        w_accNext     = r_acc;
        w_mNext       = r_m;
        w_outDataNext = r_outData;
        w_outNdNext   = 1'b0;
        w_outMNext    = r_outM;
        w_errorNext   = r_error;
        if (io_stream.in_nd) begin
            if (w_blockEmpty || io_stream.in_start) begin
                w_errorNext = r_error | (io_stream.in_start & ~w_blockEmpty);
                w_accNext   = w_ext;
                w_mNext     = io_stream.in_m;
                w_cntNext   = CW'(1);
            end else if (w_lastSample) begin
                w_outDataNext = r_acc + w_ext;
                w_outMNext    = r_m;
                w_outNdNext   = 1'b1;
                w_accNext     = '0;
                w_cntNext     = '0;
            end else begin
                w_accNext = r_acc + w_ext;
                w_cntNext = r_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_m       <= '0;
            r_outData <= '0;
            r_outNd   <= 1'b0;
            r_outM    <= '0;
            r_error   <= 1'b0;
        end else begin
            r_cnt     <= w_cntNext;
            r_acc     <= w_accNext;
            r_m       <= w_mNext;
            r_outData <= w_outDataNext;
            r_outNd   <= w_outNdNext;
            r_outM    <= w_outMNext;
            r_error   <= w_errorNext;
        end
    end

    assign io_stream.out_data = r_outData;
    assign io_stream.out_nd   = r_outNd;
    assign io_stream.out_m    = r_outM;
    assign io_stream.error    = r_error;
endmodule

// File: doc/integrate_dump.md
# integrate_dump

Integrate-and-dump decimator that sits directly downstream of the `nothing` pass-through stage and consumes its `out_data`/`out_nd`/`out_m` stream. It sums each block of DECIM consecutive valid samples and emits one widened sum per block, carrying the metadata of the block's first sample. A start marker keeps block boundaries aligned with the source. A sticky `error` flags any marker that arrives mid-block.

## Interface
- WDTH, 32, input sample width (two's complement).
- DECIM, 8, samples per block; must be ≥ 2.
- LOG_DECIM, 3, ceil(log2(DECIM)); output growth bits.
- MWDTH, 1, metadata width.

- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- in_data  in  WDTH  input sample, signed.
- in_nd  in  1  input sample valid this cycle.
- in_m  in  MWDTH  metadata for the sample; sampled only when in_nd=1.
- in_start  in  1  marks the sample as first of a block; ignored when in_nd=0.
- out_data  out  WDTH+LOG_DECIM  block sum, signed.
- out_nd  out  1  one-cycle pulse: out_data/out_m valid.
- out_m  out  MWDTH  metadata captured from first sample of the block.
- error  out  1  sticky block-misalignment flag.

## Operation
- State: sample counter cnt (0..DECIM-1), accumulator acc (WDTH+LOG_DECIM bits), metadata register m_reg (MWDTH).
- Input is sign-extended to WDTH+LOG_DECIM bits before addition. DECIM ≤ 2^LOG_DECIM, so the sum cannot overflow; no saturation logic.
- in_nd=0: no state change; out_nd=0.
- in_nd=1, cnt=0 (any in_start): acc←ext(in_data); m_reg←in_m; cnt←1.
- in_nd=1, 0<cnt<DECIM-1, in_start=0: acc←acc+ext(in_data); cnt←cnt+1.
- in_nd=1, cnt=DECIM-1, in_start=0: out_data←acc+ext(in_data); out_m←m_reg; out_nd←1; cnt←0; acc←0.
- in_nd=1, cnt≠0, in_start=1 (misalignment):
  - error←1.
  - The partial block is discarded; no output is produced for it.
  - The sample is treated as the first of a new block: acc←ext(in_data); m_reg←in_m; cnt←1.
- error stays high until rst_n is asserted. Operation continues normally after an error.
- out_data and out_m hold their last value between pulses.
- No back-pressure: the downstream stage must accept every out_nd pulse.
- Back-to-back blocks with no gaps are supported: a sample arriving in the cycle after a dump starts the next block.

## Timing
- Reset (rst_n=0, asynchronous):
  - cnt=0, acc=0, m_reg=0.
  - out_data=0, out_nd=0, out_m=0, error=0.
- A partial block in progress at reset is discarded. The first valid sample after release starts a new block.
- Latency: out_nd rises on the clock edge that samples the DECIM-th valid input, i.e. it is visible in the cycle after that input's in_nd.
- out_nd is high for exactly one cycle per completed block.
- Maximum rate: one out_nd per DECIM cycles when in_nd is continuously high.
- Gaps in in_nd stretch the block but do not change the sum.
- If in_start=1 and cnt=DECIM-1 in the same cycle, misalignment takes priority: no dump, error set, new block begun.

## Test plan
All tests use WDTH=8, DECIM=4, LOG_DECIM=2, MWDTH=1.
- Basic sum: consecutive samples 1,2,3,4 with in_start=1 on the first sample and in_m=1 on the first sample → one out_nd pulse in the cycle after sample 4, out_data=10, out_m=1, error=0.
- Extremes: four samples of −128 → out_data=−512 (10'h200). Then four samples of 127 → out_data=508. No wrap on either.
- Gapped input: samples 5,−3,7,1 separated by 0–3 idle cycles each → single out_nd one cycle after the 4th valid sample, out_data=10. out_nd=0 during all gaps.
- Misalignment:
  - Stimulus: samples 1,2, then 5 with in_start=1 and in_m=1, then 6,7,8.
  - error=1 from the cycle after sample 5 and stays high.
  - No output for the {1,2} block.
  - Output out_data=26, out_m=1.
  - A following aligned block still produces correct sums with error held at 1.
- Reset mid-block:
  - Stimulus: samples 9,9, then pulse rst_n low asynchronously (not clock-aligned), then release, then four samples of 1.
  - All outputs read 0 while reset is asserted.
  - Result after release: out_data=4, error=0.
- Back-to-back: eight consecutive samples 1..8 with in_m=1 on sample 1 and in_m=0 on sample 5 → two out_nd pulses exactly 4 cycles apart, with out_data=10,out_m=1 then out_data=26,out_m=0.
